// File: rtl/ex_commit_stage.sv
// ex_commit_stage
// Purpose:
//   Single-entry commit buffer between the ALU and writeback. It evaluates
//   each instruction's execute condition against speculative flags at accept
//   time. It holds the result for one writeback handshake and updates the
//   architectural C/Z flags only when an executed entry retires.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   alu_out, alu_zero,
//   alu_carry             ALU result and flags
//   cond                  00 always, 01 if C, 10 if Z, 11 never
//   wr_c, wr_z            instruction writes C / Z when executed
//   rd_addr               destination register
//   flush                 drop the held entry, roll speculative flags back
//   out_valid / out_ready output handshake
//   out_result, out_rd,
//   out_wen               held entry (out_wen=1 means it executed)
//   flag_c, flag_z        architectural flags
//
// Optional feature (macro EX_COMMIT_PERF_EN):
//   perf_exec, perf_squash  saturating counts of retired entries with
//                           out_wen=1 / out_wen=0. Reset clears them;
//                           flush does not.
module ex_commit_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic [1:0]  cond,
  input  logic        wr_c,
  input  logic        wr_z,
  input  logic [2:0]  rd_addr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [2:0]  out_rd,
  output logic        out_wen,
  output logic        flag_c,
  output logic        flag_z
`ifdef EX_COMMIT_PERF_EN
  ,
  output logic [15:0] perf_exec,
  output logic [15:0] perf_squash
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic accept;
  logic handshake;
  logic exec;

  // Speculative flags reflect every accepted, executed instruction, so a
  // dependent conditional right behind it sees the new value with no bubble.
  logic spec_c;
  logic spec_z;

  // Flag payload of the held entry; the set bits are already qualified by exec.
  logic held_c;
  logic held_z;
  logic held_set_c;
  logic held_set_z;

  assign out_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Flush wins over everything: it blocks both the accept and the retire.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    handshake  = 1'b0;
    accept     = 1'b0;
    exec       = 1'b0;

    unique case (cond)
      2'b00:   exec = 1'b1;
      2'b01:   exec = spec_c;
      2'b10:   exec = spec_z;
      default: exec = 1'b0;
    endcase

    if (flush) begin
      state_next = EMPTY;
    end else begin
      in_ready  = (state == EMPTY) || out_ready;
      handshake = (state == FULL) && out_ready;
      accept    = in_valid && in_ready;
      if (accept) begin
        state_next = FULL;
      end else if (handshake) begin
        state_next = EMPTY;
      end
    end
  end

  // Payload loads only on accept, so it stays stable while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_result <= 16'h0000;
      out_rd     <= 3'd0;
      out_wen    <= 1'b0;
      held_c     <= 1'b0;
      held_z     <= 1'b0;
      held_set_c <= 1'b0;
      held_set_z <= 1'b0;
    end else if (accept) begin
      out_result <= alu_out;
      out_rd     <= rd_addr;
      out_wen    <= exec;
      held_c     <= alu_carry;
      held_z     <= alu_zero;
      held_set_c <= wr_c && exec;
      held_set_z <= wr_z && exec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spec_c <= 1'b0;
      spec_z <= 1'b0;
    end else if (flush) begin
      spec_c <= flag_c;
      spec_z <= flag_z;
    end else if (accept && exec) begin
      if (wr_c) begin
        spec_c <= alu_carry;
      end
      if (wr_z) begin
        spec_z <= alu_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (handshake && out_wen) begin
      if (held_set_c) begin
        flag_c <= held_c;
      end
      if (held_set_z) begin
        flag_z <= held_z;
      end
    end
  end

`ifdef EX_COMMIT_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_exec   <= 16'h0000;
      perf_squash <= 16'h0000;
    end else if (handshake) begin
      if (out_wen) begin
        if (perf_exec != 16'hFFFF) begin
          perf_exec <= perf_exec + 16'd1;
        end
      end else begin
        if (perf_squash != 16'hFFFF) begin
          perf_squash <= perf_squash + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_commit_stage.sv
// tb_ex_commit_stage
// Purpose: self-checking bench for ex_commit_stage. It runs a directed table
// of cycle-by-cycle vectors, then randomized traffic against a queue-based
// reference model. With EX_COMMIT_PERF_EN it also checks that the counters
// saturate.
`timescale 1ns/1ps
module tb_ex_commit_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic        alu_carry;
  logic [1:0]  cond;
  logic        wr_c;
  logic        wr_z;
  logic [2:0]  rd_addr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_rd;
  logic        out_wen;
  logic        flag_c;
  logic        flag_z;
`ifdef EX_COMMIT_PERF_EN
  logic [15:0] perf_exec;
  logic [15:0] perf_squash;
`endif

  ex_commit_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .cond       (cond),
    .wr_c       (wr_c),
    .wr_z       (wr_z),
    .rd_addr    (rd_addr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_wen    (out_wen),
    .flag_c     (flag_c),
    .flag_z     (flag_z)
`ifdef EX_COMMIT_PERF_EN
    ,
    .perf_exec  (perf_exec),
    .perf_squash(perf_squash)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [15:0] alu;
    logic        z;
    logic        c;
    logic [1:0]  cnd;
    logic        wc;
    logic        wz;
    logic [2:0]  rd;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        chk_rdy;
    logic        e_rdy;
    logic        e_v;
    logic        chk_data;
    logic [15:0] e_res;
    logic [2:0]  e_rd;
    logic        e_wen;
    logic        e_c;
    logic        e_z;
  } row_t;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  rd;
    logic        wen;
    logic        c;
    logic        z;
    logic        set_c;
    logic        set_z;
  } entry_t;

  int vecCount = 0;
  int errCount = 0;

  // Reference model: at most one held entry, plus the two flag pairs.
  entry_t held[$];
  bit     m_spec_c, m_spec_z, m_arch_c, m_arch_z;
  int     m_exec, m_squash;

  function automatic row_t mkRow(
    input logic rst, fl, iv, ordy, input logic [15:0] alu,
    input logic z, c, input logic [1:0] cnd, input logic wc, wz,
    input logic [2:0] rd, input logic chk_rdy, e_rdy, e_v, chk_data,
    input logic [15:0] e_res, input logic [2:0] e_rd,
    input logic e_wen, e_c, e_z);
    row_t r;
    r.s.rst = rst; r.s.fl = fl; r.s.iv = iv; r.s.ordy = ordy;
    r.s.alu = alu; r.s.z = z; r.s.c = c; r.s.cnd = cnd;
    r.s.wc = wc; r.s.wz = wz; r.s.rd = rd;
    r.chk_rdy = chk_rdy; r.e_rdy = e_rdy; r.e_v = e_v;
    r.chk_data = chk_data; r.e_res = e_res; r.e_rd = e_rd;
    r.e_wen = e_wen; r.e_c = e_c; r.e_z = e_z;
    return r;
  endfunction

  task automatic applyStimulus(input stim_t s);
    reset     = s.rst;
    flush     = s.fl;
    in_valid  = s.iv;
    out_ready = s.ordy;
    alu_out   = s.alu;
    alu_zero  = s.z;
    alu_carry = s.c;
    cond      = s.cnd;
    wr_c      = s.wc;
    wr_z      = s.wz;
    rd_addr   = s.rd;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep(input stim_t s);
    entry_t e;
    bit ready, take;
    if (s.rst) begin
      held.delete();
      m_spec_c = 0; m_spec_z = 0; m_arch_c = 0; m_arch_z = 0;
      m_exec = 0; m_squash = 0;
    end else if (s.fl) begin
      held.delete();
      m_spec_c = m_arch_c;
      m_spec_z = m_arch_z;
    end else begin
      ready = (held.size() == 0) || s.ordy;
      if (held.size() != 0 && s.ordy) begin
        e = held.pop_front();
        if (e.wen) begin
          if (e.set_c) m_arch_c = e.c;
          if (e.set_z) m_arch_z = e.z;
          if (m_exec < 65535) m_exec++;
        end else begin
          if (m_squash < 65535) m_squash++;
        end
      end
      if (s.iv && ready) begin
        take = (s.cnd == 2'd0) || (s.cnd == 2'd1 && m_spec_c) ||
               (s.cnd == 2'd2 && m_spec_z);
        e.res = s.alu; e.rd = s.rd; e.wen = take;
        e.c = s.c; e.z = s.z;
        e.set_c = take && s.wc; e.set_z = take && s.wz;
        held.push_back(e);
        if (take && s.wc) m_spec_c = s.c;
        if (take && s.wz) m_spec_z = s.z;
      end
    end
  endtask

  function automatic stim_t randStim();
    stim_t s;
    s.rst  = ($urandom_range(0, 63) == 0);
    s.fl   = ($urandom_range(0, 9) == 0);
    s.iv   = ($urandom_range(0, 9) < 7);
    s.ordy = ($urandom_range(0, 9) < 6);
    s.alu  = 16'($urandom);
    s.z    = 1'($urandom);
    s.c    = 1'($urandom);
    s.cnd  = 2'($urandom);
    s.wc   = 1'($urandom);
    s.wz   = 1'($urandom);
    s.rd   = 3'($urandom);
    return s;
  endfunction

  row_t  tbl[$];
  stim_t rs;
  stim_t ps;

  initial begin
    rs = '{rst: 1'b0, fl: 1'b0, iv: 1'b0, ordy: 1'b0, alu: 16'h0,
           z: 1'b0, c: 1'b0, cnd: 2'b00, wc: 1'b0, wz: 1'b0, rd: 3'd0};
    applyStimulus(rs);

    //              rst fl iv or alu      z  c  cnd   wc wz rd   crdy erdy v  cd res      rd  wen c  z
    tbl.push_back(mkRow(1, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 0, 0, 3'd0, 0, 0, 0, 1, 16'h0000, 3'd0, 0, 0, 0));
    tbl.push_back(mkRow(0, 0, 1, 1, 16'h8000, 0, 0, 2'b00, 1, 1, 3'd3, 1, 1, 1, 1, 16'h8000, 3'd3, 1, 0, 0));
    tbl.push_back(mkRow(0, 0, 0, 1, 16'h0000, 0, 0, 2'b00, 0, 0, 3'd0, 1, 1, 0, 0, 16'h0000, 3'd0, 0, 0, 0));
    tbl.push_back(mkRow(0, 0, 1, 1, 16'h0000, 1, 1, 2'b00, 1, 1, 3'd1, 1, 1, 1, 1, 16'h0000, 3'd1, 1, 0, 0));
    tbl.push_back(mkRow(0, 0, 1, 1, 16'h1234, 0, 0, 2'b01, 0, 0, 3'd2, 1, 1, 1, 1, 16'h1234, 3'd2, 1, 1, 1));
    tbl.push_back(mkRow(0, 0, 1, 1, 16'h0042, 0, 0, 2'b10, 0, 0, 3'd4, 1, 1, 1, 1, 16'h0042, 3'd4, 1, 1, 1));
    tbl.push_back(mkRow(0, 0, 1, 1, 16'h0005, 0, 0, 2'b00, 1, 1, 3'd5, 1, 1, 1, 1, 16'h0005, 3'd5, 1, 1, 1));
    tbl.push_back(mkRow(0, 0, 1, 1, 16'h0006, 1, 1, 2'b01, 1, 1, 3'd6, 1, 1, 1, 1, 16'h0006, 3'd6, 0, 0, 0));
    tbl.push_back(mkRow(0, 0, 0, 1, 16'h0000, 0, 0, 2'b00, 0, 0, 3'd0, 1, 1, 0, 0, 16'h0000, 3'd0, 0, 0, 0));
    tbl.push_back(mkRow(0, 0, 1, 0, 16'hABCD, 0, 1, 2'b00, 1, 1, 3'd7, 1, 1, 1, 1, 16'hABCD, 3'd7, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mkRow(0, 0, 1, 0, 16'h1111, 0, 0, 2'b00, 0, 0, 3'd1, 1, 0, 1, 1, 16'hABCD, 3'd7, 1, 0, 0));
    tbl.push_back(mkRow(0, 0, 1, 1, 16'h2222, 0, 0, 2'b01, 0, 0, 3'd2, 1, 1, 1, 1, 16'h2222, 3'd2, 1, 1, 0));
    tbl.push_back(mkRow(0, 0, 0, 1, 16'h0000, 0, 0, 2'b00, 0, 0, 3'd0, 1, 1, 0, 0, 16'h0000, 3'd0, 0, 1, 0));
    tbl.push_back(mkRow(0, 0, 1, 1, 16'h0001, 0, 0, 2'b00, 1, 1, 3'd1, 1, 1, 1, 1, 16'h0001, 3'd1, 1, 1, 0));
    tbl.push_back(mkRow(0, 0, 0, 1, 16'h0000, 0, 0, 2'b00, 0, 0, 3'd0, 1, 1, 0, 0, 16'h0000, 3'd0, 0, 0, 0));
    tbl.push_back(mkRow(0, 0, 1, 0, 16'h0000, 1, 1, 2'b00, 1, 0, 3'd2, 1, 1, 1, 1, 16'h0000, 3'd2, 1, 0, 0));
    tbl.push_back(mkRow(0, 1, 1, 1, 16'h9999, 0, 1, 2'b00, 1, 1, 3'd3, 1, 0, 0, 0, 16'h0000, 3'd0, 0, 0, 0));
    tbl.push_back(mkRow(0, 0, 1, 1, 16'h0777, 0, 0, 2'b01, 0, 0, 3'd3, 1, 1, 1, 1, 16'h0777, 3'd3, 0, 0, 0));
    tbl.push_back(mkRow(0, 0, 1, 1, 16'h0000, 1, 1, 2'b00, 1, 1, 3'd4, 1, 1, 1, 1, 16'h0000, 3'd4, 1, 0, 0));
    tbl.push_back(mkRow(1, 1, 1, 1, 16'h5555, 1, 1, 2'b00, 1, 1, 3'd5, 1, 0, 0, 1, 16'h0000, 3'd0, 0, 0, 0));
    tbl.push_back(mkRow(0, 0, 1, 1, 16'h0101, 0, 0, 2'b01, 0, 0, 3'd5, 1, 1, 1, 1, 16'h0101, 3'd5, 0, 0, 0));
    tbl.push_back(mkRow(0, 0, 1, 1, 16'h0202, 1, 1, 2'b11, 1, 1, 3'd6, 1, 1, 1, 1, 16'h0202, 3'd6, 0, 0, 0));
    tbl.push_back(mkRow(0, 0, 1, 1, 16'h0303, 0, 0, 2'b10, 0, 0, 3'd7, 1, 1, 1, 1, 16'h0303, 3'd7, 0, 0, 0));
    tbl.push_back(mkRow(0, 0, 0, 1, 16'h0000, 0, 0, 2'b00, 0, 0, 3'd0, 1, 1, 0, 0, 16'h0000, 3'd0, 0, 0, 0));

    $display("[TB] directed table: %0d rows", tbl.size());
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].s);
      #1;
      if (tbl[i].chk_rdy)
        checkOutput($sformatf("row%0d in_ready", i), 16'(in_ready), 16'(tbl[i].e_rdy));
      @(posedge clk);
      modelStep(tbl[i].s);
      #1;
      checkOutput($sformatf("row%0d out_valid", i), 16'(out_valid), 16'(tbl[i].e_v));
      if (tbl[i].chk_data) begin
        checkOutput($sformatf("row%0d out_result", i), out_result, tbl[i].e_res);
        checkOutput($sformatf("row%0d out_rd", i), 16'(out_rd), 16'(tbl[i].e_rd));
        checkOutput($sformatf("row%0d out_wen", i), 16'(out_wen), 16'(tbl[i].e_wen));
      end
      checkOutput($sformatf("row%0d flag_c", i), 16'(flag_c), 16'(tbl[i].e_c));
      checkOutput($sformatf("row%0d flag_z", i), 16'(flag_z), 16'(tbl[i].e_z));
    end

    $display("[TB] randomized traffic against reference model");
    rs.rst = 1'b1;
    applyStimulus(rs);
    @(posedge clk);
    modelStep(rs);
    #1;
    for (int n = 0; n < 3000; n++) begin
      ps = randStim();
      applyStimulus(ps);
      #1;
      if (!ps.rst)
        checkOutput("rand in_ready", 16'(in_ready),
                    16'(!ps.fl && (held.size() == 0 || ps.ordy)));
      @(posedge clk);
      modelStep(ps);
      #1;
      checkOutput("rand out_valid", 16'(out_valid), 16'(held.size() != 0));
      if (held.size() != 0) begin
        checkOutput("rand out_result", out_result, held[0].res);
        checkOutput("rand out_rd", 16'(out_rd), 16'(held[0].rd));
        checkOutput("rand out_wen", 16'(out_wen), 16'(held[0].wen));
      end
      checkOutput("rand flag_c", 16'(flag_c), 16'(m_arch_c));
      checkOutput("rand flag_z", 16'(flag_z), 16'(m_arch_z));
`ifdef EX_COMMIT_PERF_EN
      checkOutput("rand perf_exec", perf_exec, 16'(m_exec));
      checkOutput("rand perf_squash", perf_squash, 16'(m_squash));
`endif
    end

`ifdef EX_COMMIT_PERF_EN
    // First edge only accepts; every later edge retires one executed entry.
    $display("[TB] perf counter saturation");
    rs = '{rst: 1'b1, fl: 1'b0, iv: 1'b0, ordy: 1'b0, alu: 16'h0,
           z: 1'b0, c: 1'b0, cnd: 2'b00, wc: 1'b0, wz: 1'b0, rd: 3'd0};
    applyStimulus(rs);
    @(posedge clk);
    #1;
    rs.rst = 1'b0; rs.iv = 1'b1; rs.ordy = 1'b1; rs.alu = 16'h00AA;
    applyStimulus(rs);
    repeat (65535) @(posedge clk);
    #1;
    checkOutput("perf_exec 0xFFFE", perf_exec, 16'hFFFE);
    @(posedge clk);
    #1;
    checkOutput("perf_exec 0xFFFF", perf_exec, 16'hFFFF);
    @(posedge clk);
    #1;
    checkOutput("perf_exec saturated", perf_exec, 16'hFFFF);
    checkOutput("perf_squash idle", perf_squash, 16'h0000);
    rs.iv = 1'b0; rs.fl = 1'b1;
    applyStimulus(rs);
    @(posedge clk);
    #1;
    checkOutput("perf_exec after flush", perf_exec, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/ex_commit_stage.md
EX_COMMIT_STAGE -- requirements
Module: ex_commit_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 in_valid  in  1  ALU result presented.
REQ-004 in_ready  out  1  stage can accept this cycle.
REQ-005 alu_out  in  16  ALU result.
REQ-006 alu_zero, alu_carry  in  1 each  ALU flags; alu_carry is 0 for NAND ops.
REQ-007 cond  in  2  execute condition: 00 always, 01 if C set, 10 if Z set, 11 never (bubble).
REQ-008 wr_c, wr_z  in  1 each  instruction updates C / Z when executed.
REQ-009 rd_addr  in  3  destination register.
REQ-010 flush  in  1  discard held entry and restore speculative flags.
REQ-011 out_valid  out  1  entry held for writeback.
REQ-012 out_ready  in  1  writeback accepts entry.
REQ-013 out_result  out  16  registered result.
REQ-014 out_rd  out  3  registered destination.
REQ-015 out_wen  out  1  entry executed; register write required.
REQ-016 flag_c, flag_z  out  1 each  architectural flags.

Function
REQ-017 Accept when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-018 Latency: accepted input appears on out_* the next cycle; 1 entry of storage.
REQ-019 Speculative flags spec_c/spec_z: condition evaluated at accept against spec flags; exec = (cond==00) | (cond==01 & spec_c) | (cond==10 & spec_z).
REQ-020 On accept with exec=1: spec_c <= alu_carry if wr_c; spec_z <= alu_zero if wr_z; otherwise both unchanged.
REQ-021 On accept with exec=0: spec flags unchanged, entry still passes with out_wen=0.
REQ-022 Held entry also stores its flag values and write enables; architectural flags update only on output handshake (out_valid && out_ready) of an entry with out_wen=1.
REQ-023 Back-to-back dependent conditionals see the immediately preceding accepted instruction's flags (no bubble).
REQ-024 out_* stable while out_valid && !out_ready.
REQ-025 flush (priority over all else except reset): out_valid <= 0, spec_c/spec_z <= flag_c/flag_z, no accept that cycle (in_ready forced 0), no architectural update even if out_ready=1.
REQ-026 Simultaneous output handshake and accept: arch update from old entry and spec update from new entry both occur the same edge.
REQ-027 Two-state control: EMPTY (out_valid=0) -> FULL on accept; FULL -> EMPTY on handshake without accept; FULL -> FULL on handshake with accept; any -> EMPTY on flush.

Reset
REQ-028 reset: out_valid=0, out_result=0, out_rd=0, out_wen=0, flag_c=flag_z=0, spec_c=spec_z=0; in_ready=1 the cycle after.
REQ-029 reset overrides flush, accept and handshake in the same cycle; an entry in flight is lost.

Configuration
REQ-030 Macro EX_COMMIT_PERF_EN defined: adds outputs perf_exec (16) and perf_squash (16), saturating counters of handshaken entries with out_wen=1 / out_wen=0; cleared by reset, not by flush.
REQ-031 Macro undefined: those ports and counters are absent; all other behaviour is identical.

Verification
REQ-032 ADD 0x7FFF+0x0001, cond=00, wr_c=wr_z=1, out_ready=1 -> next cycle out_result=0x8000, out_wen=1; flag_c=0, flag_z=0 after the handshake.
REQ-033 Result 0x0000 with carry=1 and wr_c=wr_z=1, then cond=01 the next cycle -> second entry out_wen=1; with cond=10 instead -> also out_wen=1; with prior carry=0 and cond=01 -> out_wen=0, flags unchanged.
REQ-034 out_ready=0 for 3 cycles with entry held -> in_ready=0, out_* stable, flag_c/flag_z unchanged; out_ready=1 -> handshake, new accept on the same edge.
REQ-035 Accept entry setting C=1, then flush before its handshake -> out_valid=0, spec_c restored to 0, next cond=01 entry gets out_wen=0.
REQ-036 reset asserted together with flush, in_valid and out_ready -> all outputs equal reset values next cycle, no flag change.
REQ-037 With EX_COMMIT_PERF_EN: 0xFFFF executed handshakes -> perf_exec=0xFFFF and stays 0xFFFF after the next one.
